// File: rtl/act_pipe_unit_if.sv
// act_pipe_unit_if
// Stream bundle for the activation stage: the flat multi-source sample bus
// with its valid/ready on the input side, and the post-activation sample with
// destination enables and valid/ready on the output side.
//   slave  : the activation stage (consumes in_*, produces out_*)
//   master : the environment (MAC array side and routing fabric side)
interface act_pipe_unit_if #(
    parameter int DATA_W  = 16,
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC*DATA_W-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         out_data;
    logic [1:0]                out_en;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_en, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_en, out_valid
    );
endinterface

// File: rtl/act_pipe_unit.sv
// act_pipe_unit
// Two-stage pipelined activation: selects one of NUM_SRC pre-activation
// sources and applies identity / ReLU / leaky ReLU / clamped ReLU, chosen by a
// run-time config register. Output is a valid/ready stream tagged with two
// destination enables.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rtm_en          retime enable; low freezes the pipeline (config still loads)
//   cfg_we/cfg_data config write: [1:0] mode, [4:2] src, [6:5] oen
//   bus (slave)     in_data/in_valid/in_ready, out_data/out_en/out_valid/out_ready
// Optional (macro ACT_STAT_EN):
//   stat_clr        clears stat_cnt
//   stat_cnt        saturating count of emitted samples altered by the function
module act_pipe_unit #(
    parameter int              DATA_W      = 16,
    parameter int              NUM_SRC     = 4,
    parameter int              LEAKY_SHIFT = 3,
    parameter logic [DATA_W-1:0] CLAMP_MAX = 16'h0600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rtm_en,
    input  logic        cfg_we,
    input  logic [6:0]  cfg_data,
`ifdef ACT_STAT_EN
    input  logic        stat_clr,
    output logic [15:0] stat_cnt,
`endif
    act_pipe_unit_if.slave bus
);
    localparam logic signed [DATA_W-1:0] CLAMP_S = CLAMP_MAX;

    logic [1:0] cfg_mode;
    logic [2:0] cfg_src;
    logic [1:0] cfg_oen;

    logic                     s1_v;
    logic signed [DATA_W-1:0] s1_x;
    logic [1:0]               s1_mode;
    logic [1:0]               s1_oen;

    logic                     s2_v;
    logic [DATA_W-1:0]        s2_y;
    logic [1:0]               s2_oen;

    logic                     s1_adv, s2_adv, accept;
    logic signed [DATA_W-1:0] sel_x;
    logic signed [DATA_W-1:0] f_y;

    assign s2_adv = rtm_en & (~s2_v | bus.out_ready);
    assign s1_adv = rtm_en & (~s1_v | s2_adv);
    assign accept = bus.in_valid & s1_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_v;
    assign bus.out_data  = s2_y;
    assign bus.out_en    = s2_oen;

    // Out-of-range source indices fall through to zero, which is still emitted.
    always_comb begin
        sel_x = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (cfg_src == 3'(k)) sel_x = bus.in_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        f_y = s1_x;
        case (s1_mode)
            2'b01: if (s1_x < 0) f_y = '0;
            2'b10: if (s1_x < 0) f_y = s1_x >>> LEAKY_SHIFT;
            2'b11: begin
                if (s1_x < 0)            f_y = '0;
                else if (s1_x > CLAMP_S) f_y = CLAMP_S;
            end
            default: f_y = s1_x;
        endcase
    end

    // Config loads independently of rtm_en; a sample accepted on the same edge
    // still sees the old value because S1 samples cfg_* before the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_mode <= '0;
            cfg_src  <= '0;
            cfg_oen  <= '0;
        end else if (cfg_we) begin
            cfg_mode <= cfg_data[1:0];
            cfg_src  <= cfg_data[4:2];
            cfg_oen  <= cfg_data[6:5];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_x    <= '0;
            s1_mode <= '0;
            s1_oen  <= '0;
        end else if (s1_adv) begin
            s1_v <= bus.in_valid;
            if (accept) begin
                s1_x    <= sel_x;
                s1_mode <= cfg_mode;
                s1_oen  <= cfg_oen;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v   <= 1'b0;
            s2_y   <= '0;
            s2_oen <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_y   <= f_y;
                s2_oen <= s1_oen;
            end
        end
    end

`ifdef ACT_STAT_EN
    // "Modified" means the function took its non-identity branch, so a leaky
    // shift of -1 counts even though the value comes out unchanged.
    logic f_mod;
    logic s2_mod;

    always_comb begin
        f_mod = 1'b0;
        case (s1_mode)
            2'b01, 2'b10: f_mod = (s1_x < 0);
            2'b11:        f_mod = (s1_x < 0) || (s1_x > CLAMP_S);
            default:      f_mod = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_mod <= 1'b0;
        end else if (s2_adv && s1_v) begin
            s2_mod <= f_mod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr || cfg_we) begin
            stat_cnt <= '0;
        end else if (rtm_en && s2_v && bus.out_ready && s2_mod && stat_cnt != 16'hFFFF) begin
            stat_cnt <= stat_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: doc/act_pipe_unit.md
Name: act_pipe_unit

Overview:
Parametrised, pipelined activation stage that replaces the single-function ReLU retime cell. It selects one of NUM_SRC pre-activation sources and applies one of four run-time selectable functions: identity, ReLU, leaky ReLU or clamped ReLU. The result goes out over a valid/ready stream tagged with destination enables. It sits between the MAC array outputs and the inter-PE routing fabric, and config is written by the PE sequencer.

Parameters:
DATA_W, 16, signed two's-complement sample width
NUM_SRC, 4, number of selectable input sources (1..8)
LEAKY_SHIFT, 3, arithmetic right-shift applied to negative samples in leaky mode (slope 2^-LEAKY_SHIFT)
CLAMP_MAX, 16'h0600, upper bound for clamped mode (positive, < 2^(DATA_W-1))

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rtm_en  in  1  retime enable; low freezes the whole pipeline
cfg_we  in  1  config write strobe
cfg_data  in  7  [1:0] mode, [4:2] src, [6:5] oen
in_data  in  NUM_SRC*DATA_W  flat source bus; source k at bits [k*DATA_W +: DATA_W]
in_valid  in  1  input sample valid
in_ready  out  1  input accept
out_data  out  DATA_W  post-activation sample
out_en  out  2  destination enables carried with the sample (bit0 port-1, bit1 port-2)
out_valid  out  1  output valid
out_ready  in  1  downstream accept

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: cfg=0 (identity, src 0, oen 00); both stage valids 0; out_valid=0, out_data=0, out_en=0; in_ready follows its equation below.
- Config register:
  - Loaded on cfg_we regardless of pipeline state.
  - A sample accepted in the same cycle as cfg_we uses the OLD config.
  - Each accepted sample captures mode and oen into the pipeline, so in-flight samples are never affected by later writes.
- Source select: src < NUM_SRC selects in_data slice src. src >= NUM_SRC yields 0. The 0 is still a valid sample.
- Stage 1 (S1) registers the selected pre-activation plus mode and oen. Stage 2 (S2) registers f(x) plus oen and drives out_*.
- Modes:
  - 00 identity: f(x)=x.
  - 01 ReLU: f(x) = x<0 ? 0 : x.
  - 10 leaky: f(x) = x<0 ? x>>>LEAKY_SHIFT : x. Arithmetic shift, rounding toward -inf; -1 maps to -1.
  - 11 clamp: f(x) = x<0 ? 0 : (x>CLAMP_MAX ? CLAMP_MAX : x). The comparison is signed.
- Handshake:
  - s2_adv = rtm_en & (!s2_v | out_ready).
  - s1_adv = rtm_en & (!s1_v | s2_adv).
  - in_ready = s1_adv.
  - A sample is accepted when in_valid & in_ready.
  - S1 is written when s1_adv. Its new valid is the accept condition; when not accepting, S1 drains.
  - S2 loads from S1 when s2_adv. S2 valid clears when out_ready fires and S1 was empty.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput is 1 sample/cycle.
- Stall: out_ready low with S2 valid holds out_data, out_en and out_valid stable. S1 still fills if empty. in_ready drops only when both stages are full.
- rtm_en low: in_ready=0, no register changes except the config register. out_valid and out_data stay held. out_ready in that cycle does not pop.
- Mid-operation rst clears both valids within the cycle; in-flight data is discarded.

Optional Feature:
- Macro: ACT_STAT_EN.
- When defined, adds output stat_cnt[15:0] and input stat_clr. stat_cnt counts samples leaving S2 (out_valid & out_ready) whose value was modified by the function: zeroed, shifted or clamped.
  - The counter saturates at 16'hFFFF.
  - It is cleared by rst, by stat_clr, or by cfg_we.
  - When a clear and an increment coincide, clear wins.
- When undefined, neither port nor counter exists and the behaviour is otherwise identical.

Test Plan:
- Reset then identity: rst 2 cycles, cfg 0, source0 = 16'hFF80, valid 1 cycle, out_ready=1 -> out_valid 2 cycles later with 16'hFF80, out_en=00.
- ReLU/leaky/clamp sweep (src=1, oen=11, out_ready=1):
  - mode 01 on {-5, 7} -> {0, 7}.
  - mode 10 (LEAKY_SHIFT=3) on {-16, -1, 9} -> {-2, -1, 9}.
  - mode 11 on {-3, 16'h0700, 16'h0100} -> {0, 16'h0600, 16'h0100}.
  - out_en=11 throughout.
- Invalid source: src=5 with NUM_SRC=4 -> 0 emitted with out_valid.
- Backpressure: stream 6 back-to-back samples, out_ready low cycles 3-6:
  - in_ready falls after 2 accepts while stalled.
  - out_data is held stable during the stall.
  - No loss or duplication; order is preserved.
- Config race: cfg_we to mode 01 in the same cycle as accepting -4 under mode 00 -> output -4; the next sample -4 -> 0.
- rtm_en low for 3 cycles with S2 full and out_ready=1 -> no pop and in_ready=0; pop occurs on the first cycle rtm_en returns. With ACT_STAT_EN, stat_cnt increments only for the modified samples and clears on cfg_we.
